// File: rtl/libv_spec_queue_if.sv
// Handshake bundle for libv_spec_queue: producer push, speculative pop,
// commit/replay/flush control and status outputs.
interface libv_spec_queue_if #(
  parameter int W       = 32,
  parameter int N       = 16,
  parameter int CMT_MAX = 4
);
  localparam int PW = $clog2(N) + 1;
  localparam int CW = $clog2(CMT_MAX + 1);

  logic          push_vld;
  logic [W-1:0]  push_data;
  logic          push_rdy;
  logic          pop_vld;
  logic [W-1:0]  pop_data;
  logic          pop_rdy;
  logic          commit_vld;
  logic [CW-1:0] commit_n;
  logic          replay;
  logic          flush;
  logic          err;
  logic [PW-1:0] spec_cnt;
  logic [PW-1:0] arch_cnt;

  // The queue itself is the slave; producer and consumer together form the master.
  modport slave (
    input  push_vld, push_data, pop_rdy, commit_vld, commit_n, replay, flush,
    output push_rdy, pop_vld, pop_data, err, spec_cnt, arch_cnt
  );

  modport master (
    output push_vld, push_data, pop_rdy, commit_vld, commit_n, replay, flush,
    input  push_rdy, pop_vld, pop_data, err, spec_cnt, arch_cnt
  );
endinterface

// File: rtl/libv_spec_queue.sv
// Speculative replay FIFO with wr/spec/arch pointers (MSB is the wrap bit).
// Define LIBV_SPEC_QUEUE_OCC_EN to get registered spec_cnt/arch_cnt counters.
module libv_spec_queue #(
  parameter int W       = 32,
  parameter int N       = 16,
  parameter int CMT_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  libv_spec_queue_if.slave   bus
);
  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CMT_MAX + 1);

  logic [W-1:0]  mem [N];

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] spec_q, spec_d;
  logic [PW-1:0] arch_q, arch_d;
  logic          err_q, err_d;

  logic          pushRdy;
  logic          popVld;
  logic          pushFire;
  logic          popFire;
  logic          commitFire;
  logic [PW-1:0] inFlight;
  logic [PW-1:0] commitReq;
  logic [PW-1:0] advance;
  logic          overCommit;

  // Status comes from registers only; popped-but-uncommitted entries still hold space.
  assign pushRdy = (wr_q - arch_q) != PW'(N);
  assign popVld  = (wr_q != spec_q);

  assign bus.push_rdy = pushRdy;
  assign bus.pop_vld  = popVld;
  assign bus.pop_data = mem[spec_q[AW-1:0]];
  assign bus.err      = err_q;

  assign pushFire   = bus.push_vld & pushRdy & ~bus.flush;
  assign popFire    = popVld & bus.pop_rdy & ~bus.replay & ~bus.flush;
  assign commitFire = bus.commit_vld & ~bus.flush;
  assign inFlight   = spec_q - arch_q;
  assign commitReq  = PW'(bus.commit_n);

  // Commit advance is clamped to both CMT_MAX and the popped-but-uncommitted count.
  always_comb begin
    advance    = '0;
    overCommit = 1'b0;
    if (commitFire) begin
      advance = commitReq;
      if (advance > PW'(CMT_MAX)) begin
        advance = PW'(CMT_MAX);
      end
      if (advance > inFlight) begin
        advance = inFlight;
      end
      overCommit = (commitReq > inFlight) | (commitReq > PW'(CMT_MAX));
    end
  end

  // Flush overrides everything; replay rewinds spec onto the post-commit arch.
  always_comb begin
    wr_d   = wr_q;
    spec_d = spec_q;
    arch_d = arch_q;
    err_d  = err_q | overCommit;
    if (bus.flush) begin
      wr_d   = '0;
      spec_d = '0;
      arch_d = '0;
    end else begin
      arch_d = arch_q + advance;
      if (pushFire) begin
        wr_d = wr_q + PW'(1);
      end
      if (bus.replay) begin
        spec_d = arch_d;
      end else if (popFire) begin
        spec_d = spec_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      spec_q <= '0;
      arch_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      spec_q <= spec_d;
      arch_q <= arch_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem[wr_q[AW-1:0]] <= bus.push_data;
    end
  end

`ifdef LIBV_SPEC_QUEUE_OCC_EN
  logic [PW-1:0] specCnt_q;
  logic [PW-1:0] archCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      specCnt_q <= '0;
      archCnt_q <= '0;
    end else begin
      specCnt_q <= wr_d - spec_d;
      archCnt_q <= wr_d - arch_d;
    end
  end

  assign bus.spec_cnt = specCnt_q;
  assign bus.arch_cnt = archCnt_q;
`else
  assign bus.spec_cnt = '0;
  assign bus.arch_cnt = '0;
`endif

endmodule

// File: tb/tb_libv_spec_queue.sv
// Randomized self-checking bench for libv_spec_queue against a queue-based model
// of committed/popped entries. Honours LIBV_SPEC_QUEUE_OCC_EN for the counters.
module tb_libv_spec_queue;
  localparam int W       = 32;
  localparam int N       = 16;
  localparam int CMT_MAX = 4;
  localparam int PW      = $clog2(N) + 1;
  localparam int CW      = $clog2(CMT_MAX + 1);

  logic clk;
  logic rst;

  libv_spec_queue_if #(.W(W), .N(N), .CMT_MAX(CMT_MAX)) bus ();

  libv_spec_queue #(.W(W), .N(N), .CMT_MAX(CMT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nChecks;
  int nErrors;

  // Model: mq holds every uncommitted entry oldest first; the first 'popped' are speculatively consumed.
  logic [W-1:0] mq[$];
  int           popped;
  bit           merr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit expired, got running, required finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit expPushRdy();
    return mq.size() != N;
  endfunction

  function automatic bit expPopVld();
    return popped < mq.size();
  endfunction

  function automatic logic [PW-1:0] expSpecCnt();
`ifdef LIBV_SPEC_QUEUE_OCC_EN
    return PW'(mq.size() - popped);
`else
    return '0;
`endif
  endfunction

  function automatic logic [PW-1:0] expArchCnt();
`ifdef LIBV_SPEC_QUEUE_OCC_EN
    return PW'(mq.size());
`else
    return '0;
`endif
  endfunction

  task automatic modelStep();
    int  adv;
    int  req;
    bit  canPush;
    bit  canPop;
    if (rst) begin
      mq.delete();
      popped = 0;
      merr   = 1'b0;
      return;
    end
    if (bus.flush) begin
      mq.delete();
      popped = 0;
      return;
    end
    canPush = expPushRdy();
    canPop  = expPopVld();
    adv = 0;
    if (bus.commit_vld) begin
      req = int'(bus.commit_n);
      if (req > popped || req > CMT_MAX) merr = 1'b1;
      adv = req;
      if (adv > CMT_MAX) adv = CMT_MAX;
      if (adv > popped) adv = popped;
    end
    if (canPop && bus.pop_rdy && !bus.replay) popped++;
    repeat (adv) void'(mq.pop_front());
    popped -= adv;
    if (bus.replay) popped = 0;
    if (bus.push_vld && canPush) mq.push_back(bus.push_data);
  endtask

  task automatic step();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    bus.push_vld   = 1'b0;
    bus.push_data  = '0;
    bus.pop_rdy    = 1'b0;
    bus.commit_vld = 1'b0;
    bus.commit_n   = '0;
    bus.replay     = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic applyStimulusReset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pushOne(input logic [W-1:0] d);
    idle();
    bus.push_vld  = 1'b1;
    bus.push_data = d;
    step();
    idle();
  endtask

  task automatic popOne();
    idle();
    bus.pop_rdy = 1'b1;
    step();
    idle();
  endtask

  task automatic commitN(input int n);
    idle();
    bus.commit_vld = 1'b1;
    bus.commit_n   = CW'(n);
    step();
    idle();
  endtask

  task automatic test_reset();
    applyStimulusReset();
    nChecks++;
    if (bus.push_rdy !== 1'b1 || bus.pop_vld !== 1'b0 || bus.err !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_status: got rdy=%b vld=%b err=%b, required rdy=1 vld=0 err=0",
               bus.push_rdy, bus.pop_vld, bus.err);
    end
    nChecks++;
    if (bus.spec_cnt !== '0 || bus.arch_cnt !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_counts: got spec=%0d arch=%0d, required 0 0", bus.spec_cnt, bus.arch_cnt);
    end
  endtask

  task automatic test_fill_retire();
    applyStimulusReset();
    for (int i = 0; i < N; i++) pushOne(W'(i));
    nChecks++;
    if (bus.push_rdy !== 1'b0 || bus.pop_vld !== 1'b1 || bus.pop_data !== 32'd0) begin
      nErrors++;
      $display("[TB] FAIL fill_full: got rdy=%b vld=%b data=%0d, required rdy=0 vld=1 data=0",
               bus.push_rdy, bus.pop_vld, bus.pop_data);
    end
    nChecks++;
    if (bus.arch_cnt !== expArchCnt() || bus.spec_cnt !== expSpecCnt()) begin
      nErrors++;
      $display("[TB] FAIL fill_counts: got spec=%0d arch=%0d, required %0d %0d",
               bus.spec_cnt, bus.arch_cnt, expSpecCnt(), expArchCnt());
    end
    for (int i = 0; i < N; i++) begin
      nChecks++;
      if (bus.pop_vld !== 1'b1 || bus.pop_data !== W'(i)) begin
        nErrors++;
        $display("[TB] FAIL fill_pop%0d: got vld=%b data=%0d, required vld=1 data=%0d",
                 i, bus.pop_vld, bus.pop_data, i);
      end
      popOne();
    end
    nChecks++;
    if (bus.pop_vld !== 1'b0 || bus.push_rdy !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL fill_drained: got vld=%b rdy=%b, required vld=0 rdy=0", bus.pop_vld, bus.push_rdy);
    end
    idle();
    bus.commit_vld = 1'b1;
    bus.commit_n   = CW'(4);
    @(negedge clk);
    nChecks++;
    if (bus.push_rdy !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL commit_same_cycle_rdy: got %b, required 0", bus.push_rdy);
    end
    step();
    for (int c = 1; c <= 4; c++) begin
      nChecks++;
      if (bus.push_rdy !== 1'b1 || bus.arch_cnt !== expArchCnt()) begin
        nErrors++;
        $display("[TB] FAIL retire%0d: got rdy=%b arch=%0d, required rdy=1 arch=%0d",
                 c, bus.push_rdy, bus.arch_cnt, expArchCnt());
      end
      if (c < 4) commitN(4);
    end
    idle();
    nChecks++;
    if (bus.err !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL retire_err: got %b, required 0", bus.err);
    end
  endtask

  task automatic test_replay();
    applyStimulusReset();
    pushOne(32'hA);
    pushOne(32'hB);
    pushOne(32'hC);
    popOne();
    popOne();
    commitN(1);
    idle();
    bus.replay = 1'b1;
    step();
    idle();
    nChecks++;
    if (bus.pop_vld !== 1'b1 || bus.pop_data !== 32'hB) begin
      nErrors++;
      $display("[TB] FAIL replay_data: got vld=%b data=%h, required vld=1 data=b", bus.pop_vld, bus.pop_data);
    end
    nChecks++;
    if (bus.arch_cnt !== expArchCnt() || bus.spec_cnt !== expSpecCnt()) begin
      nErrors++;
      $display("[TB] FAIL replay_counts: got spec=%0d arch=%0d, required %0d %0d",
               bus.spec_cnt, bus.arch_cnt, expSpecCnt(), expArchCnt());
    end
  endtask

  task automatic test_simultaneous();
    applyStimulusReset();
    pushOne(32'h11);
    pushOne(32'h22);
    pushOne(32'h33);
    popOne();
    popOne();
    idle();
    bus.push_vld   = 1'b1;
    bus.push_data  = 32'h44;
    bus.pop_rdy    = 1'b1;
    bus.commit_vld = 1'b1;
    bus.commit_n   = CW'(1);
    bus.replay     = 1'b1;
    step();
    idle();
    nChecks++;
    if (bus.pop_vld !== 1'b1 || bus.pop_data !== 32'h22) begin
      nErrors++;
      $display("[TB] FAIL simul_rewind: got vld=%b data=%h, required vld=1 data=22", bus.pop_vld, bus.pop_data);
    end
    nChecks++;
    if (bus.spec_cnt !== expSpecCnt() || bus.arch_cnt !== expArchCnt()) begin
      nErrors++;
      $display("[TB] FAIL simul_counts: got spec=%0d arch=%0d, required %0d %0d",
               bus.spec_cnt, bus.arch_cnt, expSpecCnt(), expArchCnt());
    end
    popOne();
    popOne();
    nChecks++;
    if (bus.pop_data !== 32'h44) begin
      nErrors++;
      $display("[TB] FAIL simul_push: got data=%h, required 44", bus.pop_data);
    end
  endtask

  task automatic test_overcommit();
    applyStimulusReset();
    pushOne(32'h1);
    pushOne(32'h2);
    popOne();
    popOne();
    commitN(3);
    nChecks++;
    if (bus.err !== 1'b1 || bus.arch_cnt !== expArchCnt()) begin
      nErrors++;
      $display("[TB] FAIL overcommit: got err=%b arch=%0d, required err=1 arch=%0d",
               bus.err, bus.arch_cnt, expArchCnt());
    end
    for (int i = 0; i < N; i++) pushOne(W'(100 + i));
    nChecks++;
    if (bus.push_rdy !== 1'b0 || bus.pop_data !== W'(100)) begin
      nErrors++;
      $display("[TB] FAIL overcommit_space: got rdy=%b data=%0d, required rdy=0 data=100",
               bus.push_rdy, bus.pop_data);
    end
    idle();
    bus.flush = 1'b1;
    step();
    idle();
    nChecks++;
    if (bus.err !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL err_after_flush: got %b, required 1", bus.err);
    end
    applyStimulusReset();
    nChecks++;
    if (bus.err !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL err_after_rst: got %b, required 0", bus.err);
    end
    for (int i = 0; i < 6; i++) pushOne(W'(i));
    for (int i = 0; i < 6; i++) popOne();
    commitN(5);
    nChecks++;
    if (bus.err !== 1'b1 || bus.arch_cnt !== expArchCnt() || bus.pop_vld !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL commit_over_max: got err=%b arch=%0d vld=%b, required err=1 arch=%0d vld=0",
               bus.err, bus.arch_cnt, bus.pop_vld, expArchCnt());
    end
    idle();
    bus.replay = 1'b1;
    step();
    idle();
    nChecks++;
    if (bus.pop_vld !== 1'b1 || bus.pop_data !== W'(4)) begin
      nErrors++;
      $display("[TB] FAIL commit_clamp_max: got vld=%b data=%0d, required vld=1 data=4", bus.pop_vld, bus.pop_data);
    end
  endtask

  task automatic test_flush();
    applyStimulusReset();
    for (int i = 0; i < 10; i++) pushOne(W'(200 + i));
    popOne();
    idle();
    bus.flush     = 1'b1;
    bus.push_vld  = 1'b1;
    bus.push_data = 32'hDEAD;
    bus.pop_rdy   = 1'b1;
    step();
    idle();
    nChecks++;
    if (bus.pop_vld !== 1'b0 || bus.push_rdy !== 1'b1 || bus.spec_cnt !== '0 || bus.arch_cnt !== '0) begin
      nErrors++;
      $display("[TB] FAIL flush_state: got vld=%b rdy=%b spec=%0d arch=%0d, required 0 1 0 0",
               bus.pop_vld, bus.push_rdy, bus.spec_cnt, bus.arch_cnt);
    end
    pushOne(32'hBEEF);
    nChecks++;
    if (bus.pop_vld !== 1'b1 || bus.pop_data !== 32'hBEEF) begin
      nErrors++;
      $display("[TB] FAIL flush_lost: got vld=%b data=%h, required vld=1 data=beef", bus.pop_vld, bus.pop_data);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] sent[$];
    int           nSent;
    int           nGot;
    bit           lastPop;
    applyStimulusReset();
    nSent   = 0;
    nGot    = 0;
    lastPop = 1'b0;
    for (int cyc = 0; cyc < 400 && nGot < 100; cyc++) begin
      idle();
      if (nSent < 100) begin
        bus.push_vld  = 1'b1;
        bus.push_data = $urandom;
      end
      bus.pop_rdy    = 1'b1;
      bus.commit_vld = lastPop;
      bus.commit_n   = CW'(1);
      nChecks++;
      if (bus.push_rdy !== 1'b1 || bus.pop_vld !== expPopVld()) begin
        nErrors++;
        $display("[TB] FAIL wrap_status cyc%0d: got rdy=%b vld=%b, required rdy=1 vld=%b",
                 cyc, bus.push_rdy, bus.pop_vld, expPopVld());
      end
      lastPop = bus.pop_vld;
      if (bus.pop_vld === 1'b1) begin
        nChecks++;
        if (sent.size() == 0 || bus.pop_data !== sent[0]) begin
          nErrors++;
          $display("[TB] FAIL wrap_data #%0d: got %h, required %h",
                   nGot, bus.pop_data, sent.size() ? sent[0] : '0);
        end
        if (sent.size() != 0) void'(sent.pop_front());
        nGot++;
      end
      if (bus.push_vld) begin
        sent.push_back(bus.push_data);
        nSent++;
      end
      step();
    end
    idle();
    nChecks++;
    if (nGot != 100) begin
      nErrors++;
      $display("[TB] FAIL wrap_count: got %0d entries, required 100", nGot);
    end
  endtask

  task automatic test_random();
    applyStimulusReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nChecks++;
      if (bus.push_rdy !== expPushRdy() || bus.pop_vld !== expPopVld() || bus.err !== merr ||
          bus.spec_cnt !== expSpecCnt() || bus.arch_cnt !== expArchCnt() ||
          (expPopVld() && bus.pop_data !== mq[popped])) begin
        nErrors++;
        $display("[TB] FAIL random cyc%0d: got rdy=%b vld=%b err=%b spec=%0d arch=%0d data=%h, required rdy=%b vld=%b err=%b spec=%0d arch=%0d data=%h",
                 cyc, bus.push_rdy, bus.pop_vld, bus.err, bus.spec_cnt, bus.arch_cnt, bus.pop_data,
                 expPushRdy(), expPopVld(), merr, expSpecCnt(), expArchCnt(),
                 expPopVld() ? mq[popped] : '0);
      end
      bus.push_vld   = ($urandom_range(0, 3) != 0);
      bus.push_data  = $urandom;
      bus.pop_rdy    = ($urandom_range(0, 3) != 0);
      bus.commit_vld = ($urandom_range(0, 2) == 0);
      bus.commit_n   = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 7)) : CW'($urandom_range(0, 2));
      bus.replay     = ($urandom_range(0, 19) == 0);
      bus.flush      = ($urandom_range(0, 99) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      step();
      rst = 1'b0;
    end
    idle();
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    popped  = 0;
    merr    = 1'b0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_fill_retire();
    test_replay();
    test_simultaneous();
    test_overcommit();
    test_flush();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
